// File: rtl/uart_xmit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_xmit_arbiter
// Purpose  : Round-robin arbiter that shares one UART transmitter core between
//            NUM_REQ byte sources. Accepts a byte with a valid/ready handshake,
//            strobes it into the transmitter, follows xmit_doneH through busy
//            and back to idle, then inserts GAP_CYCLES idle cycles.
// Ports    : sys_clk      - system clock, rising edge
//            sys_rst      - asynchronous active-high reset
//            req_valid    - per-requester byte pending
//            req_data     - per-requester byte, bits [8i+7:8i]
//            req_ready    - one-hot accept strobe (issued only in IDLE)
//            xmitH        - one-cycle start strobe to the transmitter
//            xmit_dataH   - byte to the transmitter, held between grants
//            xmit_doneH   - transmitter idle (1) / frame in flight (0)
//            busy         - arbiter not idle
//            grant_id     - index of the last granted requester
//            timeout_err  - one-cycle watchdog pulse
// Options  : `define UART_XMIT_ARB_TIMEOUT_EN enables the watchdog that aborts
//            a frame stuck in WAIT_BUSY/WAIT_DONE after TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xmit_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 xmitH,
  output logic [7:0]           xmit_dataH,
  input  logic                 xmit_doneH,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int c_IDX_W      = $clog2(NUM_REQ);
  localparam int c_SUM_W      = c_IDX_W + 1;
  localparam int c_GAP_W      = $clog2(GAP_CYCLES + 2);
  localparam int c_GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_LAST_I);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
  localparam logic [c_SUM_W-1:0] c_NUM      = c_SUM_W'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   last_q, last_d;
  logic [7:0]           xmit_data_q, xmit_data_d;
  logic [2:0]           grant_id_q, grant_id_d;
  logic [c_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [c_SUM_W-1:0]   w_sum;
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_IDX_W-1:0]   w_winner;
  logic                 w_found;
  logic                 w_grant;
  logic                 w_wdog_fire;

  // Round-robin search: first valid requester starting just after the last
  // winner, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    w_sum    = '0;
    w_idx    = '0;
    w_winner = last_q;
    w_found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum = {1'b0, last_q} + c_SUM_W'(i);
      if (w_sum >= c_NUM) begin
        w_sum = w_sum - c_NUM;
      end
      w_idx = w_sum[c_IDX_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // A grant also requires the transmitter to be idle, which protects against
  // a transmitter kept busy by another master.
  assign w_grant   = (state_q == IDLE) && w_found && xmit_doneH;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_winner) : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    xmit_data_d = xmit_data_q;
    grant_id_d  = grant_id_q;
    gap_cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (w_grant) begin
          xmit_data_d = req_data[w_winner*8 +: 8];
          grant_id_d  = 3'(w_winner);
          last_d      = w_winner;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      // The transmitter's done flag lags the start strobe, so first wait for
      // it to fall before waiting for it to rise again.
      WAIT_BUSY: begin
        if (!xmit_doneH) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (xmit_doneH) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == c_GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + c_GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort skips GAP; the pointer already moved past the requester.
    if (w_wdog_fire) state_d = IDLE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      last_q      <= c_LAST_RST;
      xmit_data_q <= 8'h00;
      grant_id_q  <= 3'd0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      xmit_data_q <= xmit_data_d;
      grant_id_q  <= grant_id_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef UART_XMIT_ARB_TIMEOUT_EN
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [c_WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                w_waiting;

  always_comb begin
    w_waiting     = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    w_wdog_fire   = w_waiting && (wdog_cnt_q == c_WDOG_LAST);
    wdog_cnt_d    = (w_waiting && !w_wdog_fire) ? wdog_cnt_q + c_WDOG_W'(1) : '0;
    timeout_err_d = w_wdog_fire;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wdog_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_cnt_q    <= wdog_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_wdog_fire      = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign xmitH      = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign xmit_dataH = xmit_data_q;
  assign grant_id   = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_xmit_arbiter
// Purpose  : Scoreboard bench for uart_xmit_arbiter. Stimulus pushes the
//            expected {grant_id, byte} of every accepted request; a monitor
//            pops and compares on every xmitH strobe. A small transmitter
//            model answers xmitH with a 2-cycle latency and a fixed frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_xmit_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 2;
`ifdef UART_XMIT_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 16;
`else
  localparam int TIMEOUT_CYCLES = 1024;
`endif
  localparam int FRAME_LOW = 6;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        xmitH;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH = 1'b1;
  logic        busy;
  logic [2:0]  grant_id;
  logic        timeout_err;

  bit          tx_hang = 1'b0;
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_xmit  = 0;
  logic [10:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  uart_xmit_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_grant(input string name, output logic [3:0] got);
    got = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (req_ready !== 4'b0000) begin
        got = req_ready;
        return;
      end
    end
    check({name, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (busy === 1'b0 && xmit_doneH === 1'b1) return;
    end
    check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done_level(input string name, input logic lvl);
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (xmit_doneH === lvl) return;
    end
    check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // Transmitter model: done falls 2 cycles after the start strobe and stays
  // low for FRAME_LOW cycles.
  initial begin : tx_model
    forever begin
      @(negedge sys_clk);
      if (xmitH === 1'b1 && !tx_hang) begin
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 xmit_doneH = 1'b0;
        repeat (FRAME_LOW) @(posedge sys_clk);
        #1 xmit_doneH = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(negedge sys_clk);
      if (xmitH === 1'b1) begin
        n_xmit++;
        if (exp_q.size() == 0) begin
          check("xmit_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("xmit_grant_id", 32'(grant_id), 32'(e[10:8]));
          check("xmit_data", 32'(xmit_dataH), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] g;
    int         n;
    int         base;
    bit         te;

    // Reset values
    repeat (2) @(negedge sys_clk);
    check("rst_xmitH", 32'(xmitH), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_xmit_data", 32'(xmit_dataH), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    tick();
    sys_rst = 1'b0;

    // Single request from requester 2
    tick();
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    wait_grant("single", g);
    check("single_ready", 32'(g), 32'h4);
    exp_q.push_back({3'd2, 8'hA5});
    tick();
    req_valid = '0;
    @(negedge sys_clk);
    check("single_ready_once", 32'(req_ready), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    wait_done_level("single", 1'b0);
    wait_done_level("single", 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge sys_clk);
    end
    check("single_gap_len", 32'(n), 32'(GAP_CYCLES + 1));
    check("single_grant_id", 32'(grant_id), 32'd2);

    // Skip and wrap: last=2, requesters 0 and 1 pending
    tick();
    req_data[7:0]   = 8'h3C;
    req_data[15:8]  = 8'h5A;
    req_data[31:24] = 8'hFF;
    req_valid = 4'b0011;
    wait_grant("skip0", g);
    check("skip_first", 32'(g), 32'h1);
    exp_q.push_back({3'd0, 8'h3C});
    tick();
    req_valid = 4'b0010;
    wait_grant("skip1", g);
    check("skip_second", 32'(g), 32'h2);
    exp_q.push_back({3'd1, 8'h5A});
    tick();
    req_valid = '0;
    wait_idle("skip");

    // Round-robin with all requesters held
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("rr_rst_grant_id", 32'(grant_id), 32'd0);
    base = n_xmit;
    req_data = 32'hD3D2D1D0;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr", g);
      check("rr_ready", 32'(g), 32'(4'b0001 << (k % 4)));
      exp_q.push_back({3'(k % 4), 8'hD0 + 8'(k % 4)});
    end
    tick();
    req_valid = '0;
    wait_idle("rr");
    check("rr_xmit_count", 32'(n_xmit - base), 32'd5);
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Transmitter busy from outside: no grant until done returns
    tick();
    xmit_doneH = 1'b0;
    req_data[7:0] = 8'h77;
    req_valid = 4'b0001;
    repeat (4) begin
      @(negedge sys_clk);
      check("guard_no_ready", 32'(req_ready), 32'd0);
    end
    check("guard_idle", 32'(busy), 32'd0);
    tick();
    xmit_doneH = 1'b1;
    @(negedge sys_clk);
    check("guard_ready", 32'(req_ready), 32'h1);
    exp_q.push_back({3'd0, 8'h77});
    tick();
    req_valid = '0;
    wait_idle("guard");

    // Reset in WAIT_DONE
    tick();
    req_data[15:8] = 8'h9E;
    req_valid = 4'b0010;
    wait_grant("midrst", g);
    check("midrst_ready", 32'(g), 32'h2);
    exp_q.push_back({3'd1, 8'h9E});
    tick();
    req_valid = '0;
    wait_done_level("midrst", 1'b0);
    @(negedge sys_clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    tick();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_xmitH", 32'(xmitH), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready0", 32'(req_ready), 32'd0);
    check("midrst_data", 32'(xmit_dataH), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    tick();
    sys_rst = 1'b0;
    wait_idle("midrst");

    // Watchdog: transmitter never reports busy
    tick();
    tx_hang = 1'b1;
    req_data[7:0] = 8'h42;
    req_valid = 4'b0001;
    wait_grant("wd", g);
    check("wd_ready", 32'(g), 32'h1);
    exp_q.push_back({3'd0, 8'h42});
    tick();
    req_valid = '0;
    @(negedge sys_clk);
    check("wd_issue", 32'(xmitH), 32'd1);
`ifdef UART_XMIT_ARB_TIMEOUT_EN
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    check("wd_latency", 32'(n), 32'(TIMEOUT_CYCLES + 1));
    check("wd_busy_cleared", 32'(busy), 32'd0);
    @(negedge sys_clk);
    check("wd_pulse_once", 32'(timeout_err), 32'd0);
`else
    te = 1'b0;
    repeat (40) begin
      @(negedge sys_clk);
      if (timeout_err !== 1'b0) te = 1'b1;
    end
    check("wd_never_fires", 32'(te), 32'd0);
    check("wd_busy_hangs", 32'(busy), 32'd1);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
`endif
    tx_hang = 1'b0;
    @(negedge sys_clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
